// File: rtl/vram_fill.sv
// Rectangle-fill engine: writes one colour word per clock into the clipped
// rectangle on the CPU-side port of the dual-port video RAM.
module vram_fill #(
    parameter int unsigned FB_WIDTH  = 160,
    parameter int unsigned FB_HEIGHT = 120,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned COORD_W   = 8
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [COORD_W-1:0] cmd_w,
    input  logic [COORD_W-1:0] cmd_h,
    input  logic [15:0]        cmd_color,
    output logic [15:0]        wr_addr,
    output logic [15:0]        wr_data,
    output logic               wr_en,
    output logic               busy,
    output logic               done
);

    localparam logic [COORD_W-1:0] W_C   = COORD_W'(FB_WIDTH);
    localparam logic [COORD_W-1:0] H_C   = COORD_W'(FB_HEIGHT);
    localparam logic [15:0]        ROW_STEP = 16'(FB_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [COORD_W-1:0] r_cw;
    logic [COORD_W-1:0] r_ch;
    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;
    logic [15:0]        r_row_base;

    logic               w_accept;
    logic [COORD_W-1:0] w_cw;
    logic [COORD_W-1:0] w_ch;
    logic               w_empty;
    logic               w_start;
    logic [15:0]        w_base0;
    logic               w_last_col;
    logic               w_last;

    logic               w_wr_en_nxt;
    logic [15:0]        w_wr_addr_nxt;
    logic [15:0]        w_wr_data_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_ready_nxt;

    // Command acceptance, clipping and starting address of the first row
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_cw       = (cmd_x >= W_C) ? '0 : ((cmd_w < (W_C - cmd_x)) ? cmd_w : (W_C - cmd_x));
    assign w_ch       = (cmd_y >= H_C) ? '0 : ((cmd_h < (H_C - cmd_y)) ? cmd_h : (H_C - cmd_y));
    assign w_empty    = (w_cw == '0) || (w_ch == '0);
    assign w_start    = w_accept & ~w_empty;
    assign w_base0    = BASE_ADDR + (16'(cmd_y) * ROW_STEP) + 16'(cmd_x);

    // Position of the write currently on the bus
    assign w_last_col = (r_col == (r_cw - COORD_W'(1)));
    assign w_last     = w_last_col && (r_row == (r_ch - COORD_W'(1)));

    // State register
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_empty ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Raster counters and row base address
    always_ff @(posedge clock) begin
        if (clear) begin
            r_cw       <= '0;
            r_ch       <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (w_accept) begin
            r_cw       <= w_cw;
            r_ch       <= w_ch;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= w_base0;
        end else if (r_state == S_FILL && !w_last) begin
            if (w_last_col) begin
                r_col      <= '0;
                r_row      <= r_row + COORD_W'(1);
                r_row_base <= r_row_base + ROW_STEP;
            end else begin
                r_col      <= r_col + COORD_W'(1);
            end
        end
    end

    // Next values of the registered outputs; address/data hold when idle
    always_comb begin
        w_wr_en_nxt   = (w_state_nxt == S_FILL);
        w_wr_addr_nxt = wr_addr;
        w_wr_data_nxt = wr_data;
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_done_nxt    = (w_state_nxt == S_DONE);
        w_ready_nxt   = (w_state_nxt == S_IDLE);
        if (w_start) begin
            w_wr_addr_nxt = w_base0;
            w_wr_data_nxt = cmd_color;
        end else if (r_state == S_FILL && !w_last) begin
            w_wr_addr_nxt = w_last_col ? (r_row_base + ROW_STEP)
                                       : (r_row_base + 16'(r_col) + 16'd1);
        end
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            wr_en     <= w_wr_en_nxt;
            wr_addr   <= w_wr_addr_nxt;
            wr_data   <= w_wr_data_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            cmd_ready <= w_ready_nxt;
        end
    end

endmodule

// File: tb/tb_vram_fill.sv
// Bench for vram_fill: directed and random fills checked cycle by cycle
// against an address list built from the clipping and raster rules.
module tb_vram_fill;

    localparam int FB_W = 160;
    localparam int FB_H = 120;
    localparam int BASE = 0;

    logic        clock;
    logic        clear;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [7:0]  cmd_w;
    logic [7:0]  cmd_h;
    logic [15:0] cmd_color;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    vram_fill #(
        .FB_WIDTH (160),
        .FB_HEIGHT(120),
        .BASE_ADDR(16'h0000),
        .COORD_W  (8)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x    (cmd_x),
        .cmd_y    (cmd_y),
        .cmd_w    (cmd_w),
        .cmd_h    (cmd_h),
        .cmd_color(cmd_color),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and check every cycle until the engine is idle again.
    // With inject set, a 4x1 command at (0,0) is held on the inputs during the fill.
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [15:0] color, input bit inject);
        int cw;
        int ch;
        int n;
        logic [15:0] q[$];
        cw = (x >= FB_W) ? 0 : ((w < FB_W - x) ? w : FB_W - x);
        ch = (y >= FB_H) ? 0 : ((h < FB_H - y) ? h : FB_H - y);
        for (int r = 0; r < ch; r++)
            for (int c = 0; c < cw; c++)
                q.push_back(16'(BASE + (y + r) * FB_W + x + c));
        n = cw * ch;

        @(negedge clock);
        chk("ready_before", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_x     = 8'(x);
        cmd_y     = 8'(y);
        cmd_w     = 8'(w);
        cmd_h     = 8'(h);
        cmd_color = color;
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clock);
            if (k <= n) begin
                chk("fill_wr_en", 32'(wr_en), 32'd1);
                chk("fill_addr", 32'(wr_addr), 32'(q[k-1]));
                chk("fill_data", 32'(wr_data), 32'(color));
                chk("fill_busy", 32'(busy), 32'd1);
                chk("fill_done", 32'(done), 32'd0);
                chk("fill_ready", 32'(cmd_ready), 32'd0);
            end else if (k == n + 1) begin
                chk("done_wr_en", 32'(wr_en), 32'd0);
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_busy", 32'(busy), 32'd1);
                chk("done_ready", 32'(cmd_ready), 32'd0);
                if (n > 0) chk("done_addr_hold", 32'(wr_addr), 32'(q[n-1]));
            end else begin
                chk("idle_wr_en", 32'(wr_en), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_ready", 32'(cmd_ready), 32'd1);
            end
            if (inject && k <= n) begin
                cmd_valid = 1'b1;
                cmd_x     = 8'd0;
                cmd_y     = 8'd0;
                cmd_w     = 8'd4;
                cmd_h     = 8'd1;
                cmd_color = 16'hABCD;
            end else begin
                cmd_valid = 1'b0;
            end
        end
    endtask

    initial begin
        clear     = 1'b1;
        cmd_valid = 1'b1;
        cmd_x     = 8'd1;
        cmd_y     = 8'd1;
        cmd_w     = 8'd2;
        cmd_h     = 8'd2;
        cmd_color = 16'h0123;

        // Reset held two cycles with a command pending
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        clear     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clock);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Directed fills
        run_cmd(0, 0, 1, 1, 16'h0F00, 1'b0);
        run_cmd(10, 5, 3, 2, 16'h00F0, 1'b0);
        run_cmd(158, 119, 5, 4, 16'h000F, 1'b0);
        run_cmd(200, 3, 4, 4, 16'h0555, 1'b0);
        run_cmd(5, 5, 0, 3, 16'h0AAA, 1'b0);
        run_cmd(5, 130, 2, 2, 16'h0777, 1'b0);

        // Command presented while busy is ignored; the next one is taken
        run_cmd(20, 30, 3, 2, 16'h0321, 1'b1);
        run_cmd(0, 0, 4, 1, 16'hF00F, 1'b0);

        // Reset in the middle of an 8x8 fill, after the 5th write
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_x     = 8'd0;
        cmd_y     = 8'd0;
        cmd_w     = 8'd8;
        cmd_h     = 8'd8;
        cmd_color = 16'h0BEE;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("mid_5th_addr", 32'(wr_addr), 32'd4);
        chk("mid_5th_en", 32'(wr_en), 32'd1);
        clear = 1'b1;
        @(negedge clock);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        clear = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            chk("mid_after_wr_en", 32'(wr_en), 32'd0);
            chk("mid_after_done", 32'(done), 32'd0);
            chk("mid_after_ready", 32'(cmd_ready), 32'd1);
        end
        run_cmd(3, 2, 2, 2, 16'h0C0C, 1'b0);

        // Random commands, some landing near or past the edges
        for (int t = 0; t < 25; t++) begin
            run_cmd(int'($urandom_range(0, 200)), int'($urandom_range(0, 140)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                    16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
